// File: rtl/t_switch_fc.sv
// t_switch_fc: buffered, flow-controlled three-port switch of a binary fat-tree.
// Port index order everywhere is L=0, R=1, U=2. Each input has a FIFO, each
// output a round-robin arbiter over the other two inputs and an output register.
module t_switch_fc #(
    parameter int unsigned num_leaves = 8,
    parameter int unsigned payload_sz = 4,
    parameter int unsigned level      = 0,
    parameter int unsigned addr       = 0,
    parameter int unsigned fifo_depth = 4,
    localparam int unsigned A    = $clog2(num_leaves),
    localparam int unsigned p_sz = 1 + A + payload_sz
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [p_sz-1:0] l_bus_i,
    input  logic [p_sz-1:0] r_bus_i,
    input  logic [p_sz-1:0] u_bus_i,
    output logic            l_ready_o,
    output logic            r_ready_o,
    output logic            u_ready_o,
    output logic [p_sz-1:0] l_bus_o,
    output logic [p_sz-1:0] r_bus_o,
    output logic [p_sz-1:0] u_bus_o,
    input  logic            l_ready_i,
    input  logic            r_ready_i,
    input  logic            u_ready_i,
    output logic            err_o
);

    localparam int unsigned PW       = $clog2(fifo_depth);
    localparam int unsigned CW       = PW + 1;
    localparam bit          IsRoot   = (level == A - 1);
    localparam logic [31:0] AddrBits = 32'(addr);

    localparam logic [1:0] PortL = 2'd0;
    localparam logic [1:0] PortR = 2'd1;
    localparam logic [1:0] PortU = 2'd2;

    // Destination prefix test; at the root the loop body never fires, so
    // everything stays inside this subtree.
    function automatic logic [1:0] route_of(input logic [A-1:0] d);
        logic match;
        match = 1'b1;
        for (int i = 0; i < int'(A); i++) begin
            if (i > int'(level)) begin
                if (d[i] != AddrBits[i - int'(level) - 1]) match = 1'b0;
            end
        end
        if (match) return d[level] ? PortR : PortL;
        return PortU;
    endfunction

    logic [p_sz-1:0] bus_in [3];
    logic [2:0]      rdy_in;

    assign bus_in[0] = l_bus_i;
    assign bus_in[1] = r_bus_i;
    assign bus_in[2] = u_bus_i;
    assign rdy_in    = {u_ready_i, r_ready_i, l_ready_i};

    logic [p_sz-1:0] mem_q [3][fifo_depth];
    logic [PW-1:0]   rd_q  [3];
    logic [PW-1:0]   wr_q  [3];
    logic [CW-1:0]   cnt_q [3];
    logic [p_sz-1:0] out_q [3];
    logic [p_sz-1:0] out_d [3];
    logic [2:0]      ptr_q;
    logic [2:0]      ptr_d;
    logic            err_q;

    logic [p_sz-1:0] head [3];
    logic [1:0]      rt   [3];
    logic [2:0]      hv;
    logic [2:0]      uturn;
    logic [2:0]      rdy;
    logic [2:0]      push;
    logic [2:0]      pop;
    logic [1:0]      c0;
    logic [1:0]      c1;
    logic            req0;
    logic            req1;
    logic            load;
    logic            gnt0;
    logic            gnt1;

    // FIFO heads, routing, per-output arbitration and next output register state
    always_comb begin
        pop  = '0;
        c0   = PortL;
        c1   = PortL;
        req0 = 1'b0;
        req1 = 1'b0;
        load = 1'b0;
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            head[i]  = mem_q[i][rd_q[i]];
            hv[i]    = (cnt_q[i] != '0);
            rt[i]    = route_of(head[i][p_sz-2:payload_sz]);
            uturn[i] = hv[i] && (rt[i] == 2'(i));
            // Ready depends only on registered count; the U port is dead at the root.
            rdy[i]   = !reset && (cnt_q[i] < CW'(fifo_depth)) && !(IsRoot && (i == 2));
            push[i]  = bus_in[i][p_sz-1] && rdy[i];
            pop[i]   = uturn[i];
        end
        for (int o = 0; o < 3; o++) begin
            // Candidates in L, R, U order; c0 is the lower-indexed one.
            c0   = (o == 0) ? PortR : PortL;
            c1   = (o == 2) ? PortR : PortU;
            req0 = hv[c0] && (rt[c0] == 2'(o));
            req1 = hv[c1] && (rt[c1] == 2'(o));
            load = !out_q[o][p_sz-1] || rdy_in[o];
            gnt0 = load && req0 && (!req1 || !ptr_q[o]);
            gnt1 = load && req1 && (!req0 || ptr_q[o]);
            out_d[o] = out_q[o];
            ptr_d[o] = ptr_q[o];
            if (gnt0) begin
                out_d[o] = head[c0];
                pop[c0]  = 1'b1;
                ptr_d[o] = 1'b1;
            end else if (gnt1) begin
                out_d[o] = head[c1];
                pop[c1]  = 1'b1;
                ptr_d[o] = 1'b0;
            end else if (load) begin
                out_d[o] = '0;
            end
        end
    end

    // Pointers, counts, output registers, RR pointers and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                rd_q[i]  <= '0;
                wr_q[i]  <= '0;
                cnt_q[i] <= '0;
                out_q[i] <= '0;
            end
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (push[i]) wr_q[i] <= wr_q[i] + PW'(1);
                if (pop[i])  rd_q[i] <= rd_q[i] + PW'(1);
                cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
                out_q[i] <= out_d[i];
            end
            ptr_q <= ptr_d;
            err_q <= err_q | (|uturn);
        end
    end

    // FIFO storage; push is already forced low during reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (push[i]) mem_q[i][wr_q[i]] <= bus_in[i];
        end
    end

    assign l_ready_o = rdy[0];
    assign r_ready_o = rdy[1];
    assign u_ready_o = rdy[2];
    assign l_bus_o   = out_q[0];
    assign r_bus_o   = out_q[1];
    assign u_bus_o   = IsRoot ? '0 : out_q[2];
    assign err_o     = err_q;

endmodule

// File: doc/t_switch_fc.md
# t_switch_fc

Flow-controlled, buffered successor to the three-port T-switch of the binary fat-tree packet network. Each of the left, right and up ports has an input FIFO of parametrised depth and a ready/valid handshake. Packets are routed by destination leaf address. Per-output round-robin arbitration and an output register give full throughput under backpressure. It sits at any tree level, including the root, between leaf interfaces or child switches below and a parent switch above.

## Interface
- `num_leaves`, 8: leaves in the whole tree; power of 2, ≥2. `A = $clog2(num_leaves)`.
- `payload_sz`, 4: payload bits per packet.
- `level`, 0: switch level, 0 (next to leaves) to A-1 (root).
- `addr`, 0: subtree prefix, width `A-level-1` (unused at the root).
- `fifo_depth`, 4: entries per input FIFO; power of 2, ≥2.
- `p_sz`, `1+A+payload_sz`: packet width. Bus format is {valid[p_sz-1], dest[p_sz-2:payload_sz], payload}.
- `clk`  in  1  single clock, all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `l_bus_i`, `r_bus_i`, `u_bus_i`  in  p_sz  incoming packet; MSB is valid.
- `l_ready_o`, `r_ready_o`, `u_ready_o`  out  1  port may accept a packet this cycle.
- `l_bus_o`, `r_bus_o`, `u_bus_o`  out  p_sz  outgoing packet; MSB is valid.
- `l_ready_i`, `r_ready_i`, `u_ready_i`  in  1  downstream accepts this cycle.
- `err_o`  out  1  sticky: a misrouted packet was dropped.

## Operation
- **Transfer rule (every port, both directions):** a transfer occurs on an edge where bus valid=1 and ready=1.
  - Valid with ready=0 is not a transfer. The sender holds the packet.
  - The switch never changes `*_bus_o` while its valid=1 and `*_ready_i`=0.
- **Input FIFOs:**
  - `*_ready_o` = (count < fifo_depth). It is derived only from registered count, with no combinational path from any `*_ready_i`.
  - The FIFO stores only accepted packets. Simultaneous push and pop on a full FIFO is not possible because ready_o=0, so there is no push.
- **Route of a FIFO head packet with destination d:**
  - If level==A-1, or d[A-1:level+1]==addr: the route is d[level]==0 → LEFT, else → RIGHT.
  - Otherwise the route is UP.
- **U-turn:** a head whose route equals its own arrival port is popped without output, and err_o is set to 1 until reset. Example: left-arrived head routed LEFT.
- **Arbitration:** each output has two candidate inputs (the other two ports).
  - An output stage may load when its register is empty or is transferring this cycle.
  - One round-robin pointer per output selects between the two candidates when both request. After a grant the pointer moves to the other candidate; with no grant it is unchanged.
  - One input can request only one output, so there is no input-side conflict.
- **Output register:** loads the granted head and pops that FIFO on the same edge. If the register transfers and nothing is granted, it loads 0 (valid=0).
- **Root (level==A-1):**
  - u_ready_o=0 and u_bus_o=0 permanently, and u_bus_i is ignored.
  - UP is never produced at the root, because the prefix test is vacuous.

## Timing
- Reset, effective on the edge where reset=1:
  - FIFOs empty; all `*_bus_o`=0; err_o=0; RR pointers prefer the lower-indexed candidate (order L, R, U).
  - All `*_ready_o`=0 during reset. After reset they are 1, except u_ready_o at the root.
- Reset mid-operation discards all buffered and registered packets with no partial output.
- **Latency:** a packet accepted at edge k is visible on `*_bus_o` after edge k+1 (2-cycle minimum) if the FIFO is empty and the output is free.
- **Throughput:** one packet per cycle per output with ready_i held at 1.
- **Backpressure:** with ready_i=0, a FIFO fills after fifo_depth accepts, and ready_o falls on the edge of the last push.
- A U-turn drop pops at the head's arbitration slot and costs one cycle on that input.

## Test plan
All scenarios use num_leaves=8, payload_sz=4 (p_sz=8), level=1 and addr=1'b0, so this subtree covers leaves 0–3 (left 0–1, right 2–3).
1. **Basic routing:** l_bus_i=8'b1_010_1010 (dest 2) for one cycle, all ready_i=1 → r_bus_o=8'b1_010_1010 two edges later for exactly one cycle; l_bus_o and u_bus_o stay 0.
2. **Up and down routing:** l sends dest 5 → u_bus_o. u sends dest 1 → l_bus_o. Both are in flight concurrently, each with 2-cycle latency.
3. **Contention:** l and u both send to dest 3 (right) every cycle for 6 cycles → r_bus_o alternates l, u, l, u… with no gaps and no loss.
4. **Backpressure:** r_ready_i=0 while l streams dest-2 packets → r_bus_o holds the first packet stable. l_ready_o drops after 4 more accepts (depth 4 + output register). Raising r_ready_i drains all 5 in order.
5. **U-turn:** l sends dest 0 → no output on any port; err_o=1 from the next edge and stays 1 until reset.
6. **Root instance:** level=2 → u_ready_o=0, u_bus_o=0. A reset asserted mid-stream clears every output to 0 and restores ready_o=1 on l and r after reset.
